// File: rtl/md_sched_pkg.sv
// Shared opcodes, FSM encoding and default latencies for the multiply/divide unit.
// Also used by the hazard controller and the E-stage decoder.
package md_sched_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;
    localparam int DEF_CNT_W    = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_sched_if.sv
// E/D-stage side bundle of the multiply/divide unit; slave is the unit itself.
// No handshake: the unit answers with a combinational stall request.
interface md_sched_if;
    logic [2:0]  E_md_op;
    logic        E_valid;
    logic [31:0] E_data1;
    logic [31:0] E_data2;
    logic        D_is_md;
    logic        md_stall;
    logic        md_busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        md_err;

    modport master (
        output E_md_op, E_valid, E_data1, E_data2, D_is_md,
        input  md_stall, md_busy, HI, LO, md_err
    );

    modport slave (
        input  E_md_op, E_valid, E_data1, E_data2, D_is_md,
        output md_stall, md_busy, HI, LO, md_err
    );
endinterface

// File: rtl/md_arith.sv
// Combinational HI/LO result generator for mult/multu/div/divu; zero latency.
// No backpressure; a zero divisor returns the current HI/LO so nothing changes.
module md_arith
    import md_sched_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] cur_hi,
    input  logic [31:0] cur_lo,
    output logic [31:0] pend_hi,
    output logic [31:0] pend_lo
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_u;
    logic [31:0] r_u;

    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes: avoids the INT_MIN / -1 overflow case.
    assign mag_a = a[31] ? (~a + 32'd1) : a;
    assign mag_b = b[31] ? (~b + 32'd1) : b;
    assign q_mag = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
    assign r_mag = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
    assign q_u   = (b == 32'd0) ? 32'd0 : a / b;
    assign r_u   = (b == 32'd0) ? 32'd0 : a % b;

    always_comb begin
        pend_hi = cur_hi;
        pend_lo = cur_lo;
        case (op)
            MD_MULT: begin
                pend_hi = prod_s[63:32];
                pend_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                pend_hi = prod_u[63:32];
                pend_lo = prod_u[31:0];
            end
            MD_DIV: begin
                if (b != 32'd0) begin
                    pend_lo = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
                    pend_hi = a[31] ? (~r_mag + 32'd1) : r_mag;
                end
            end
            MD_DIVU: begin
                if (b != 32'd0) begin
                    pend_lo = q_u;
                    pend_hi = r_u;
                end
            end
            default: begin
                pend_hi = cur_hi;
                pend_lo = cur_lo;
            end
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle mult/div sequencer owning HI/LO; results commit MULT_LAT/DIV_LAT cycles after start.
// Backpressure: md_stall holds an md instruction in D while busy or starting; starts while busy flag md_err.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    md_sched_if.slave  bus
);

    md_state_t   state;
    logic [CNT_W-1:0] cnt;
    logic [31:0] pend_hi_q;
    logic [31:0] pend_lo_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        err_q;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        start;
    logic        write;
    logic        is_mult;

    assign start   = bus.E_valid && (bus.E_md_op >= MD_MULT) && (bus.E_md_op <= MD_DIVU);
    assign write   = bus.E_valid && ((bus.E_md_op == MD_MTHI) || (bus.E_md_op == MD_MTLO));
    assign is_mult = (bus.E_md_op == MD_MULT) || (bus.E_md_op == MD_MULTU);

    md_arith u_arith (
        .op      (bus.E_md_op),
        .a       (bus.E_data1),
        .b       (bus.E_data2),
        .cur_hi  (hi_q),
        .cur_lo  (lo_q),
        .pend_hi (res_hi),
        .pend_lo (res_lo)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pend_hi_q <= res_hi;
                        pend_lo_q <= res_lo;
                        cnt       <= is_mult ? CNT_W'(MULT_LAT - 1) : CNT_W'(DIV_LAT - 1);
                        state     <= BUSY;
                    end else if (write) begin
                        if (bus.E_md_op == MD_MTHI) hi_q <= bus.E_data1;
                        else                        lo_q <= bus.E_data1;
                    end
                end
                BUSY: begin
                    // Anything arriving now is a hazard-controller bug; flag it and keep going.
                    if (start || write) err_q <= 1'b1;
                    if (cnt == '0) begin
                        hi_q  <= pend_hi_q;
                        lo_q  <= pend_lo_q;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.md_busy  = (state == BUSY);
    assign bus.md_stall = bus.D_is_md && ((state == BUSY) || start);
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
    assign bus.md_err   = err_q;

endmodule
